// File: rtl/lab03_pkg.sv
// Shared types and constants for the lab03 instruction fetch unit.
// Holds the fetch FSM state encoding, instruction width and HALT encoding.
package lab03_pkg;

  localparam int INSTR_W = 16;

  localparam logic [INSTR_W-1:0] HALT_WORD = 16'hFFFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT,
    S_HALTED,
    S_ERROR
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_prog_mem.sv
// Program store: DEPTH x INSTR_W register array.
// Ports: clk, we/waddr/wdata (synchronous write), raddr/rdata (comb. read).
module prog_mem
  import lab03_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [INSTR_W-1:0] rdata
);

  logic [INSTR_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction sequencer: fetches words from prog_mem, pulses run, waits
// for done. Ports: clk, reset (async low), load_*, prog_len, start, abort,
// done in; instruction, run, pc, busy, halted, error, retired_count out.
module instr_fetch_unit
  import lab03_pkg::*;
#(
  parameter int                 DEPTH     = 16,
  parameter int                 ADDR_W    = $clog2(DEPTH),
  parameter int                 TIMEOUT   = 8,
  parameter logic [INSTR_W-1:0] HALT_WORD = lab03_pkg::HALT_WORD
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_en,
  input  logic [ADDR_W-1:0]  load_addr,
  input  logic [INSTR_W-1:0] load_data,
  input  logic [ADDR_W:0]    prog_len,
  input  logic               start,
  input  logic               abort,
  input  logic               done,
  output logic [INSTR_W-1:0] instruction,
  output logic               run,
  output logic [ADDR_W-1:0]  pc,
  output logic               busy,
  output logic               halted,
  output logic               error,
  output logic [15:0]        retired_count
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LEN_ONE = (ADDR_W+1)'(1);
  localparam logic [TW-1:0]   T_LAST  = TW'(TIMEOUT - 1);

  fetch_state_t       state;
  logic [ADDR_W:0]    len_q;
  logic [TW-1:0]      timer;
  logic [INSTR_W-1:0] rdata;
  logic               stopped;
  logic               mem_we;
  logic               last;
  logic [ADDR_W:0]    len_clamp;
  logic [15:0]        count_nxt;

  assign stopped = (state == S_IDLE) ||
                   (state == S_HALTED) ||
                   (state == S_ERROR);

  assign mem_we = load_en && stopped;

  assign len_clamp = (prog_len > LEN_MAX) ? LEN_MAX : prog_len;

  // len_q is never 0 while sequencing, so len_q-1 cannot underflow here
  assign last = ({1'b0, pc} == (len_q - LEN_ONE));

  assign count_nxt = (retired_count == 16'hFFFF) ?
                     retired_count : retired_count + 16'd1;

  assign run    = (state == S_ISSUE);
  assign busy   = (state == S_FETCH) ||
                  (state == S_ISSUE) ||
                  (state == S_WAIT);
  assign halted = (state == S_HALTED);
  assign error  = (state == S_ERROR);

  prog_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (load_addr),
    .wdata (load_data),
    .raddr (pc),
    .rdata (rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      pc            <= '0;
      instruction   <= '0;
      retired_count <= '0;
      timer         <= '0;
      len_q         <= '0;
    end else begin
      unique case (state)
        S_IDLE, S_HALTED, S_ERROR: begin
          if (start) begin
            pc            <= '0;
            retired_count <= '0;
            len_q         <= len_clamp;
            state <= (len_clamp == '0) ? S_HALTED : S_FETCH;
          end
        end
        S_FETCH: begin
          if (abort) begin
            state <= S_IDLE;
          end else begin
            instruction <= rdata;
            state <= (rdata == HALT_WORD) ? S_HALTED : S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (abort) begin
            state <= S_IDLE;
          end else begin
            timer <= '0;
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (abort) begin
            state <= S_IDLE;
          end else if (done) begin
            retired_count <= count_nxt;
            if (last) begin
              state <= S_HALTED;
            end else begin
              pc    <= pc + ADDR_W'(1);
              state <= S_FETCH;
            end
          end else if (timer == T_LAST) begin
            state <= S_ERROR;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
